ifu: RTL and testbench

Instruction fetch unit feeding the single-cycle core's decode/execute path. It owns the architectural PC and issues one instruction read at a time on a valid/ready memory port. It presents each fetched word with its PC to the core through a valid/ready output handshake, and accepts PC redirects from execute.

---
 rtl/ifu_pkg.sv | 22 ++
 rtl/ifu_pc_gen.sv | 36 +++
 rtl/ifu.sv | 166 ++++++++++++++++
 tb/tb_ifu.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StHold
  } ifu_state_t;

  typedef enum logic [1:0] {
    PcHold,
    PcStep,
    PcRedirect,
    PcReset
  } pc_sel_t;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] IFU_NOP      = 32'h0000_0013;
  localparam logic [31:0] IFU_PC_STEP  = 32'd4;

endpackage

// File: rtl/ifu_pc_gen.sv
// Combinational next-PC select for the fetch unit: reset, redirect, sequential step or hold.
// IFU_MISALIGN_CHECK_EN keeps redirect targets unaligned so the FSM can trap them.
module ifu_pc_gen
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  pc_sel_t     sel,
  input  logic [31:0] pc,
  input  logic [31:0] redirect_pc,
  output logic [31:0] next_pc,
  output logic        misalign
);

  logic [31:0] target;

`ifdef IFU_MISALIGN_CHECK_EN
  assign target   = redirect_pc;
  assign misalign = |next_pc[1:0];
`else
  // Without the check a redirect can never produce a misaligned fetch.
  assign target   = redirect_pc & ~32'h3;
  assign misalign = 1'b0;
`endif

  always_comb begin
    next_pc = pc;
    unique case (sel)
      PcReset:    next_pc = RESET_PC;
      PcRedirect: next_pc = target;
      PcStep:     next_pc = pc + IFU_PC_STEP;
      default:    next_pc = pc;
    endcase
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, keeps one read outstanding, delivers words by valid/ready.
// Define IFU_MISALIGN_CHECK_EN to turn misaligned redirects into a flagged NOP instead of a fetch.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_misalign,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  ifu_state_t  state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic [31:0] next_pc;
  logic        squash;
  logic        misalign_q;
  logic        redirect;
  logic        trap;
  pc_sel_t     pc_sel;

  assign redirect     = redirect_valid && (state != StIdle);
  assign mem_req_addr = req_addr;
  // Constant 0 when the misalign check is compiled out.
  assign out_misalign = misalign_q;

  always_comb begin
    pc_sel = PcHold;
    if (redirect) begin
      pc_sel = PcRedirect;
    end else if (state == StHold && out_ready) begin
      pc_sel = PcStep;
    end
  end

  ifu_pc_gen #(
    .RESET_PC(RESET_PC)
  ) u_pc_gen (
    .sel        (pc_sel),
    .pc         (pc),
    .redirect_pc(redirect_pc),
    .next_pc    (next_pc),
    .misalign   (trap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= StIdle;
      pc            <= RESET_PC;
      req_addr      <= RESET_PC;
      squash        <= 1'b0;
      mem_req_valid <= 1'b0;
      out_valid     <= 1'b0;
      out_instr     <= '0;
      out_pc        <= '0;
      misalign_q    <= 1'b0;
    end else begin
      pc <= next_pc;
      unique case (state)
        StIdle: begin
          state         <= StReq;
          mem_req_valid <= 1'b1;
          req_addr      <= pc;
        end

        StReq: begin
          // The pending request cannot be withdrawn; its response is dropped later.
          if (redirect) begin
            squash <= 1'b1;
          end
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            if (redirect && trap) begin
              state      <= StHold;
              out_valid  <= 1'b1;
              misalign_q <= 1'b1;
              out_pc     <= next_pc;
              out_instr  <= IFU_NOP;
            end else begin
              state <= StWait;
            end
          end
        end

        StWait: begin
          if (mem_resp_valid && !squash && !redirect) begin
            state      <= StHold;
            out_valid  <= 1'b1;
            misalign_q <= 1'b0;
            out_instr  <= mem_resp_data;
            out_pc     <= req_addr;
          end else if (mem_resp_valid) begin
            squash <= 1'b0;
            if (trap) begin
              state      <= StHold;
              out_valid  <= 1'b1;
              misalign_q <= 1'b1;
              out_pc     <= next_pc;
              out_instr  <= IFU_NOP;
            end else begin
              state         <= StReq;
              mem_req_valid <= 1'b1;
              req_addr      <= next_pc;
            end
          end else if (redirect) begin
            squash <= 1'b1;
            if (trap) begin
              state      <= StHold;
              out_valid  <= 1'b1;
              misalign_q <= 1'b1;
              out_pc     <= next_pc;
              out_instr  <= IFU_NOP;
            end
          end
        end

        StHold: begin
          // A trap can sit here while a squashed response is still owed; absorb it in place.
          if (squash && mem_resp_valid) begin
            squash <= 1'b0;
          end
          if (redirect && trap) begin
            out_valid  <= 1'b1;
            misalign_q <= 1'b1;
            out_pc     <= next_pc;
            out_instr  <= IFU_NOP;
          end else if (redirect || out_ready) begin
            if (squash && !mem_resp_valid) begin
              state      <= StWait;
              out_valid  <= 1'b0;
              misalign_q <= 1'b0;
            end else if (trap) begin
              out_valid  <= 1'b1;
              misalign_q <= 1'b1;
              out_pc     <= next_pc;
              out_instr  <= IFU_NOP;
            end else begin
              state         <= StReq;
              out_valid     <= 1'b0;
              misalign_q    <= 1'b0;
              mem_req_valid <= 1'b1;
              req_addr      <= next_pc;
            end
          end
        end

        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed steps, then randomized traffic against a PC-stream model.
module tb_ifu;
  import ifu_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
`ifdef IFU_MISALIGN_CHECK_EN
  localparam bit MisEn = 1'b1;
`else
  localparam bit MisEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_misalign;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_tests   = 0;
  int n_fail    = 0;
  int delivered = 0;

  bit          fixed_data = 1'b1;
  bit          rand_lat   = 1'b0;
  int unsigned fixed_lat  = 1;
  bit          mem_busy   = 1'b0;

  always #5 clk = ~clk;

  ifu #(
    .RESET_PC(RST_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_misalign  (out_misalign),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (fixed_data) return 32'h0000_0093;
    return a * 32'h9E37_79B1 + 32'h1;
  endfunction

  function automatic logic [31:0] exp_instr(input logic [31:0] a);
    if (MisEn && a[1:0] != 2'b00) return IFU_NOP;
    return mem_word(a);
  endfunction

  function automatic logic [31:0] load_target(input logic [31:0] r);
    if (MisEn) return r;
    return r & ~32'h3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid(input int budget, input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, out_valid, 1);
  endtask

  // Memory: accepts a request, answers once after 1..3 cycles, forgets everything on reset.
  initial begin : mem_model
    bit          acc;
    bit          rst_s;
    logic [31:0] a_s;
    logic [31:0] p_addr;
    int unsigned cnt;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    p_addr         = '0;
    cnt            = 0;
    forever begin
      @(negedge clk);
      rst_s = rst;
      acc   = mem_req_valid && mem_req_ready;
      a_s   = mem_req_addr;
      @(posedge clk);
      #1;
      mem_resp_valid = 1'b0;
      if (rst_s) begin
        mem_busy = 1'b0;
      end else begin
        if (acc && !mem_busy) begin
          mem_busy = 1'b1;
          p_addr   = a_s;
          cnt      = rand_lat ? $urandom_range(1, 3) : fixed_lat;
        end
        if (mem_busy) begin
          cnt--;
          if (cnt == 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_word(p_addr);
            mem_busy       = 1'b0;
          end
        end
      end
    end
  end

  // Reference: delivered instructions must follow the architectural PC stream
  // (+4 per delivery, replaced by any redirect after IDLE), plus handshake rules.
  initial begin : scoreboard
    logic [31:0] arch_pc;
    int unsigned cyc;
    bit          pv_ov, pv_or, pv_rd, pv_rq, pv_rr;
    logic [31:0] pv_pc, pv_in, pv_addr;
    arch_pc = RST_PC;
    cyc     = 0;
    pv_ov   = 1'b0;
    pv_or   = 1'b0;
    pv_rd   = 1'b0;
    pv_rq   = 1'b0;
    pv_rr   = 1'b0;
    pv_pc   = '0;
    pv_in   = '0;
    pv_addr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        arch_pc = RST_PC;
        cyc     = 0;
        pv_ov   = 1'b0;
        pv_rq   = 1'b0;
      end else begin
        if (pv_ov && !pv_or && !pv_rd) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_pc", out_pc, pv_pc);
          chk("hold_instr", out_instr, pv_in);
        end
        if (pv_rq && !pv_rr) begin
          chk("req_valid_stable", mem_req_valid, 1);
          chk("req_addr_stable", mem_req_addr, pv_addr);
        end
        if (mem_busy || mem_resp_valid) chk("one_outstanding", mem_req_valid, 0);
        if (cyc == 0) chk("idle_no_req", mem_req_valid, 0);
        if (out_valid && out_ready) begin
          chk("xfer_pc", out_pc, arch_pc);
          chk("xfer_instr", out_instr, exp_instr(arch_pc));
          chk("xfer_misalign", out_misalign, {31'b0, MisEn && (arch_pc[1:0] != 2'b00)});
          arch_pc = arch_pc + 32'd4;
          delivered++;
        end
        if (redirect_valid && cyc != 0) arch_pc = load_target(redirect_pc);
        cyc++;
        pv_ov   = out_valid;
        pv_or   = out_ready;
        pv_rd   = redirect_valid;
        pv_pc   = out_pc;
        pv_in   = out_instr;
        pv_rq   = mem_req_valid;
        pv_rr   = mem_req_ready;
        pv_addr = mem_req_addr;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    if ($urandom_range(0, 15) == 0) begin
      t = 32'hFFFF_FFF8 + ($urandom_range(0, 1) << 2);
    end else begin
      t = RST_PC + ($urandom_range(0, 1023) << 2);
    end
    if ($urandom_range(0, 7) == 0) t = t + $urandom_range(1, 3);
    return t;
  endfunction

  initial begin : stim
    int  n;
    bit  saw;
    int  d0;
    rst            = 1'b1;
    mem_req_ready  = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Cycle 0: reset values.
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_req_addr", mem_req_addr, RST_PC);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_misalign", out_misalign, 0);
    mem_req_ready = 1'b1;
    out_ready     = 1'b1;

    // Zero-wait memory, first instruction at cycle 3.
    tick();
    chk("c1_req_valid", mem_req_valid, 1);
    chk("c1_req_addr", mem_req_addr, RST_PC);
    tick();
    chk("c2_out_valid", out_valid, 0);
    tick();
    chk("c3_out_valid", out_valid, 1);
    chk("c3_out_pc", out_pc, RST_PC);
    chk("c3_out_instr", out_instr, 32'h0000_0093);
    tick();
    chk("c4_req_valid", mem_req_valid, 1);
    chk("c4_req_addr", mem_req_addr, 32'h8000_0004);

    // Memory not ready for 4 cycles.
    mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_req_valid", mem_req_valid, 1);
      chk("stall_req_addr", mem_req_addr, 32'h8000_0004);
    end
    mem_req_ready = 1'b1;
    out_ready     = 1'b0;
    wait_out_valid(10, "stall_out_valid");
    chk("stall_out_pc", out_pc, 32'h8000_0004);

    // Core not ready for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_pc", out_pc, 32'h8000_0004);
      chk("bp_out_instr", out_instr, 32'h0000_0093);
      chk("bp_no_req", mem_req_valid, 0);
    end

    // Redirect and out_ready together.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    out_ready      = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk("rdh_out_valid", out_valid, 0);
    chk("rdh_req_valid", mem_req_valid, 1);
    chk("rdh_req_addr", mem_req_addr, 32'h8000_0200);

    // Redirect while waiting on a 3-cycle response.
    fixed_lat = 3;
    tick();
    chk("rdw_in_wait", mem_req_valid, 0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    saw = 1'b0;
    n   = 0;
    while (mem_req_valid !== 1'b1 && n < 10) begin
      if (out_valid === 1'b1) saw = 1'b1;
      tick();
      n++;
    end
    chk("rdw_dropped", {31'b0, saw}, 0);
    chk("rdw_req_addr", mem_req_addr, 32'h8000_0100);
    fixed_lat = 1;
    wait_out_valid(10, "rdw_out_valid");
    chk("rdw_out_pc", out_pc, 32'h8000_0100);

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("wrap_req_top", mem_req_addr, 32'hFFFF_FFFC);
    wait_out_valid(10, "wrap_out_valid");
    chk("wrap_out_pc", out_pc, 32'hFFFF_FFFC);
    tick();
    chk("wrap_req_valid", mem_req_valid, 1);
    chk("wrap_req_zero", mem_req_addr, 32'h0000_0000);

`ifdef IFU_MISALIGN_CHECK_EN
    out_ready = 1'b0;
    wait_out_valid(10, "mis_pre_valid");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    tick();
    redirect_valid = 1'b0;
    chk("mis_no_req", mem_req_valid, 0);
    chk("mis_out_valid", out_valid, 1);
    chk("mis_flag", out_misalign, 1);
    chk("mis_out_pc", out_pc, 32'h8000_0102);
    chk("mis_out_instr", out_instr, IFU_NOP);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0300;
    out_ready      = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk("mis_next_req", mem_req_valid, 1);
    chk("mis_next_addr", mem_req_addr, 32'h8000_0300);
`endif

    // Asynchronous reset in flight, then a redirect in IDLE that must be ignored.
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_req_valid", mem_req_valid, 0);
    chk("arst_req_addr", mem_req_addr, RST_PC);
    chk("arst_out_pc", out_pc, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst            = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0400;
    tick();
    redirect_valid = 1'b0;
    chk("idle_rd_req_valid", mem_req_valid, 1);
    chk("idle_rd_req_addr", mem_req_addr, RST_PC);

    // Randomized traffic with hashed instruction words and variable latency.
    rst        = 1'b1;
    fixed_data = 1'b0;
    rand_lat   = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    d0  = delivered;
    for (int i = 0; i < 3000; i++) begin
      mem_req_ready  = ($urandom_range(0, 9) < 7);
      out_ready      = ($urandom_range(0, 9) < 6);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = rand_target();
      if (i == 1500) rst = 1'b1;
      if (i == 1502) rst = 1'b0;
      tick();
    end
    redirect_valid = 1'b0;
    chk("liveness", {31'b0, (delivered - d0) >= 100}, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
